frame_encoder: RTL and testbench

//   Host-side (initiator) frame builder for the serial command link: wraps a payload byte stream

---
 rtl/frame_encoder.sv | 239 +++++++++++++++++++++++
 tb/tb_frame_encoder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_encoder.sv
// Link frame builder: stages a payload, then emits <len><0x10|seq><payload><crc_hi><crc_lo><0x7e>
// over a valid/ready byte stream. Empty ack frames can be requested at any time.
module frame_encoder #(
  parameter int MAX_PAYLOAD = 59,
  parameter int BUF_BITS    = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  input  logic       ack_req,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] seq,
  output logic       overflow,
  input  logic       clr_err
);

  localparam int CW = BUF_BITS + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PAYLOAD);

  typedef enum logic [2:0] {
    S_COLLECT, S_DROP, S_LEN, S_SEQ, S_DATA, S_CRC1, S_CRC2, S_EOF
  } state_t;

  // CRC-16/CCITT reflected (poly 0x8408), one full byte per call
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    end
    return c;
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [3:0]    seq_q, seq_d;
  logic          overflow_q, overflow_d;
  logic          ack_q, ack_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic [15:0]   crc_q, crc_d;
  logic [7:0]    mem_q [2**BUF_BITS];

  logic          in_ready_s;
  logic          wr_en_s;
  logic          hs_s;
  logic [15:0]   crc_upd_s;
  logic [7:0]    rd_data_s;

  assign in_ready  = in_ready_s & ~rst;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign seq       = seq_q;
  assign overflow  = overflow_q;

  assign hs_s      = out_valid_q & out_ready;
  assign crc_upd_s = crc16_byte(crc_q, out_data_q);
  assign rd_data_s = mem_q[idx_q[BUF_BITS-1:0]];

  // Next-state and output-register logic
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    idx_d       = idx_q;
    seq_d       = seq_q;
    overflow_d  = overflow_q;
    ack_d       = ack_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    crc_d       = crc_q;
    in_ready_s  = 1'b0;
    wr_en_s     = 1'b0;

    if (ack_req) begin
      ack_d = 1'b1;
    end else begin
      ack_d = ack_q;
    end
    if (clr_err) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end

    case (state_q)
      S_COLLECT: begin
        // A pending ack only goes out between payloads and blocks input for that cycle
        if ((ack_q | ack_req) && (count_q == {CW{1'b0}})) begin
          ack_d       = 1'b0;
          out_data_d  = 8'd5;
          out_valid_d = 1'b1;
          crc_d       = 16'hFFFF;
          state_d     = S_LEN;
        end else begin
          in_ready_s = 1'b1;
          if (in_valid) begin
            if (count_q == MAX_CNT) begin
              if (in_last) begin
                overflow_d = 1'b1;
                count_d    = {CW{1'b0}};
              end else begin
                state_d = S_DROP;
              end
            end else begin
              wr_en_s = 1'b1;
              count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
              if (in_last) begin
                out_data_d  = 8'(count_q) + 8'd6;
                out_valid_d = 1'b1;
                crc_d       = 16'hFFFF;
                state_d     = S_LEN;
              end else begin
                state_d = S_COLLECT;
              end
            end
          end else begin
            state_d = S_COLLECT;
          end
        end
      end
      S_DROP: begin
        in_ready_s = 1'b1;
        if (in_valid && in_last) begin
          overflow_d = 1'b1;
          count_d    = {CW{1'b0}};
          state_d    = S_COLLECT;
        end else begin
          state_d = S_DROP;
        end
      end
      S_LEN: begin
        if (hs_s) begin
          crc_d      = crc_upd_s;
          out_data_d = {4'b0001, seq_q};
          state_d    = S_SEQ;
        end else begin
          state_d = S_LEN;
        end
      end
      S_SEQ: begin
        if (hs_s) begin
          crc_d = crc_upd_s;
          if (count_q != {CW{1'b0}}) begin
            out_data_d = mem_q[0];
            idx_d      = {{(CW-1){1'b0}}, 1'b1};
            state_d    = S_DATA;
          end else begin
            out_data_d = crc_upd_s[15:8];
            state_d    = S_CRC1;
          end
        end else begin
          state_d = S_SEQ;
        end
      end
      S_DATA: begin
        if (hs_s) begin
          crc_d = crc_upd_s;
          if (idx_q == count_q) begin
            out_data_d = crc_upd_s[15:8];
            state_d    = S_CRC1;
          end else begin
            out_data_d = rd_data_s;
            idx_d      = idx_q + {{(CW-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_CRC1: begin
        if (hs_s) begin
          out_data_d = crc_q[7:0];
          state_d    = S_CRC2;
        end else begin
          state_d = S_CRC1;
        end
      end
      S_CRC2: begin
        if (hs_s) begin
          out_data_d = 8'h7E;
          state_d    = S_EOF;
        end else begin
          state_d = S_CRC2;
        end
      end
      S_EOF: begin
        if (hs_s) begin
          out_valid_d = 1'b0;
          seq_d       = seq_q + 4'd1;
          count_d     = {CW{1'b0}};
          state_d     = S_COLLECT;
        end else begin
          state_d = S_EOF;
        end
      end
      default: begin
        state_d = S_COLLECT;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_COLLECT;
      count_q     <= {CW{1'b0}};
      idx_q       <= {CW{1'b0}};
      seq_q       <= 4'd0;
      overflow_q  <= 1'b0;
      ack_q       <= 1'b0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      crc_q       <= 16'hFFFF;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      seq_q       <= seq_d;
      overflow_q  <= overflow_d;
      ack_q       <= ack_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      crc_q       <= crc_d;
    end
  end

  // Payload staging buffer
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[count_q[BUF_BITS-1:0]] <= in_data;
    end
  end

endmodule

// File: tb/tb_frame_encoder.sv
// Randomized directed bench for frame_encoder: a frame-level reference model fills an
// expected-byte queue that a negedge monitor compares against every output handshake.
module tb_frame_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic       ack_req;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] seq;
  logic       overflow;
  logic       clr_err;

  always #5 clk = ~clk;

  frame_encoder #(.MAX_PAYLOAD(59), .BUF_BITS(6)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .ack_req(ack_req), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .seq(seq), .overflow(overflow), .clr_err(clr_err)
  );

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic [3:0] model_seq;
  bit         rand_ready = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int crc_ref(input logic [7:0] bytes[$]);
    int c = 'hFFFF;
    foreach (bytes[i]) begin
      c = c ^ int'(bytes[i]);
      for (int k = 0; k < 8; k++) c = (c & 1) ? ((c >> 1) ^ 'h8408) : (c >> 1);
    end
    return c;
  endfunction

  // Reference model: one complete frame appended to the expected stream
  task automatic push_frame(input logic [7:0] pl[$]);
    logic [7:0] frm[$];
    int crc;
    frm.push_back(8'(pl.size() + 5));
    frm.push_back({4'h1, model_seq});
    foreach (pl[i]) frm.push_back(pl[i]);
    crc = crc_ref(frm);
    foreach (frm[i]) exp_q.push_back(frm[i]);
    exp_q.push_back(8'((crc >> 8) & 'hFF));
    exp_q.push_back(8'(crc & 'hFF));
    exp_q.push_back(8'h7E);
    model_seq = model_seq + 4'd1;
  endtask

  function automatic void rand_payload(input int n, output logic [7:0] pl[$]);
    pl = {};
    for (int i = 0; i < n; i++) pl.push_back(8'($urandom_range(0, 255)));
  endfunction

  // Output ready: always 1 unless random back-pressure is enabled
  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: byte order, no extra bytes, and hold-while-stalled
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) chk("hold_stable", {31'd0, out_valid} << 8 | 32'(out_data), {23'd0, 1'b1, prev_data});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_byte", 32'(out_data), 32'h100);
        else chk("frame_byte", 32'(out_data), 32'(exp_q.pop_front()));
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] pl[$]);
    foreach (pl[i]) begin
      int t = 0;
      in_valid = 1'b1;
      in_data  = pl[i];
      in_last  = (i == pl.size() - 1);
      forever begin
        @(negedge clk);
        if (in_ready) break;
        t++;
        if (t > 1000) begin
          chk("in_ready_timeout", 32'd0, 32'd1);
          break;
        end
      end
      cyc();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pulse_ack();
    ack_req = 1'b1;
    cyc();
    ack_req = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      cyc();
      t++;
    end
    chk("drain_left", exp_q.size(), 32'd0);
    cyc();
    cyc();
  endtask

  initial begin
    logic [7:0] pl[$];
    logic [7:0] empty[$];
    int t;
    empty = {};
    rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0;
    ack_req = 1'b0; clr_err = 1'b0; model_seq = 4'd0;
    cyc();
    cyc();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_seq", 32'(seq), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_in_ready_low", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    cyc();

    // Ack frame with literal expected bytes
    exp_q = {8'h05, 8'h10, 8'h9E, 8'h81, 8'h7E};
    model_seq = 4'd1;
    pulse_ack();
    drain();
    chk("seq_after_ack", 32'(seq), 32'd1);

    // Short payload
    pl = {8'h01, 8'h02, 8'h03};
    push_frame(pl);
    send(pl);
    drain();
    chk("seq_after_payload", 32'(seq), 32'(model_seq));

    // 17 ack frames from seq 0: SEQ bytes 10..1F then 10
    rst = 1'b1; cyc(); rst = 1'b0; model_seq = 4'd0;
    for (int k = 0; k < 17; k++) begin
      push_frame(empty);
      pulse_ack();
      drain();
    end
    chk("seq_wrap", 32'(seq), 32'd1);

    // Overflow: 60 bytes (last at the limit) and 70 bytes (drop path)
    rand_payload(60, pl);
    send(pl);
    cyc(); cyc();
    chk("ovf60_flag", 32'(overflow), 32'd1);
    chk("ovf60_seq", 32'(seq), 32'(model_seq));
    chk("ovf60_no_out", 32'(out_valid), 32'd0);
    clr_err = 1'b1; cyc(); clr_err = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);
    rand_payload(70, pl);
    send(pl);
    cyc(); cyc();
    chk("ovf70_flag", 32'(overflow), 32'd1);
    chk("ovf70_seq", 32'(seq), 32'(model_seq));
    clr_err = 1'b1; cyc(); clr_err = 1'b0;
    chk("ovf70_cleared", 32'(overflow), 32'd0);

    // Maximum payload under random back-pressure
    rand_ready = 1'b1;
    rand_payload(59, pl);
    push_frame(pl);
    send(pl);
    drain();
    rand_ready = 1'b0;
    chk("seq_after_max", 32'(seq), 32'(model_seq));

    // Ack collides with the first payload byte: ack goes first
    rand_payload(4, pl);
    push_frame(empty);
    push_frame(pl);
    ack_req = 1'b1; in_valid = 1'b1; in_data = pl[0]; in_last = 1'b0;
    #1;
    chk("ack_blocks_in_ready", 32'(in_ready), 32'd0);
    cyc();
    ack_req = 1'b0;
    send(pl);
    drain();
    chk("seq_after_collision", 32'(seq), 32'(model_seq));

    // Reset in the middle of the DATA bytes
    rand_payload(20, pl);
    push_frame(pl);
    send(pl);
    t = 0;
    while (exp_q.size() > 15 && t < 500) begin
      cyc();
      t++;
    end
    chk("reached_data", 32'(exp_q.size() <= 15), 32'd1);
    rst = 1'b1;
    exp_q.delete();
    model_seq = 4'd0;
    cyc();
    rst = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_seq", 32'(seq), 32'd0);
    rand_payload(7, pl);
    push_frame(pl);
    send(pl);
    drain();

    // Random frames and acks with random back-pressure
    rand_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        push_frame(empty);
        pulse_ack();
      end else begin
        rand_payload(int'($urandom_range(1, 59)), pl);
        push_frame(pl);
        send(pl);
      end
      drain();
    end
    rand_ready = 1'b0;
    chk("seq_final", 32'(seq), 32'(model_seq));
    chk("overflow_final", 32'(overflow), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
